// File: rtl/mux_2to1_4to1.sv
// Paired 2:1 and 4:1 data selector with combinational and one-cycle registered outputs.
// An unknown select produces an all-X result instead of silently choosing a lane.
module mux_2to1_4to1 #(
   parameter int DATA_W = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   input  logic                  sel2,
   input  logic [4*DATA_W-1:0]   d,
   input  logic [1:0]            sel4,
   output logic [DATA_W-1:0]     y2,
   output logic [DATA_W-1:0]     y4,
   output logic [DATA_W-1:0]     y2_q,
   output logic [DATA_W-1:0]     y4_q,
   output logic                  out_valid
);

   logic [DATA_W-1:0] y2_s;
   logic [DATA_W-1:0] y4_s;
   logic [DATA_W-1:0] y2_r;
   logic [DATA_W-1:0] y4_r;
   logic              valid_r;

   // 2:1 select; a non-0/1 select falls to the X default (don't-care for synthesis)
   always_comb begin
      y2_s = {DATA_W{1'b0}};
      case (sel2)
         1'b0:    y2_s = a;
         1'b1:    y2_s = b;
         default: y2_s = {DATA_W{1'bx}};
      endcase
   end

   // 4:1 lane select by binary index
   always_comb begin
      y4_s = {DATA_W{1'b0}};
      case (sel4)
         2'b00:   y4_s = d[0*DATA_W +: DATA_W];
         2'b01:   y4_s = d[1*DATA_W +: DATA_W];
         2'b10:   y4_s = d[2*DATA_W +: DATA_W];
         2'b11:   y4_s = d[3*DATA_W +: DATA_W];
         default: y4_s = {DATA_W{1'bx}};
      endcase
   end

   // Output registers: synchronous clear, load on enable, otherwise hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y2_r    <= {DATA_W{1'b0}};
         y4_r    <= {DATA_W{1'b0}};
         valid_r <= 1'b0;
      end else if (en) begin
         y2_r    <= y2_s;
         y4_r    <= y4_s;
         valid_r <= 1'b1;
      end else begin
         y2_r    <= y2_r;
         y4_r    <= y4_r;
         valid_r <= valid_r;
      end
   end

   assign y2        = y2_s;
   assign y4        = y4_s;
   assign y2_q      = y2_r;
   assign y4_q      = y4_r;
   assign out_valid = valid_r;

endmodule

// File: tb/tb_mux_2to1_4to1.sv
// Directed bench for mux_2to1_4to1: a 1-bit instance for truth tables, reset and enable,
// and an 8-bit instance for lane width and unknown-select behaviour.
module tb_mux_2to1_4to1;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       sel2;
   logic [1:0] sel4;

   logic       a1, b1;
   logic [3:0] d1;
   logic       y2_1, y4_1, y2q_1, y4q_1, ov_1;

   logic [7:0]  a8, b8;
   logic [31:0] d8;
   logic [7:0]  y2_8, y4_8, y2q_8, y4q_8;
   logic        ov_8;

   int total;
   int bad;

   mux_2to1_4to1 #(.DATA_W(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a1), .b(b1), .sel2(sel2), .d(d1), .sel4(sel4),
      .y2(y2_1), .y4(y4_1), .y2_q(y2q_1), .y4_q(y4q_1), .out_valid(ov_1)
   );

   mux_2to1_4to1 #(.DATA_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a8), .b(b8), .sel2(sel2), .d(d8), .sel4(sel4),
      .y2(y2_8), .y4(y4_8), .y2_q(y2q_8), .y4_q(y4q_8), .out_valid(ov_8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_point();
      @(negedge clk);
   endtask

   logic       exp2 [8];
   logic [3:0] vec_d [10];
   logic [1:0] vec_s [10];
   logic       vec_e [10];
   logic [7:0] exp8 [4];
   logic       probe;

   initial begin
      total = 0;
      bad   = 0;
      exp2  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vec_d = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b1010, 4'b1110, 4'b1111, 4'b0001, 4'b1000};
      vec_s = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
      vec_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      exp8  = '{8'h11, 8'h22, 8'h33, 8'h44};

      // reset held for two edges with enable and nonzero inputs
      rst_n = 1'b0; en = 1'b1; sel2 = 1'b1; sel4 = 2'b11;
      a1 = 1'b1; b1 = 1'b1; d1 = 4'b1111;
      a8 = 8'hA5; b8 = 8'h5A; d8 = 32'h44332211;
      tick();
      tick();
      check("rst_y2q_1", y2q_1, 1'b0);
      check("rst_y4q_1", y4q_1, 1'b0);
      check("rst_ov_1", ov_1, 1'b0);
      check("rst_y2q_8", y2q_8, 8'h00);
      check("rst_y4q_8", y4q_8, 8'h00);
      check("rst_ov_8", ov_8, 1'b0);

      drive_point();
      rst_n = 1'b1;
      tick();
      check("rel_ov_1", ov_1, 1'b1);
      check("rel_y2q_1", y2q_1, 1'b1);
      check("rel_y4q_1", y4q_1, 1'b1);
      check("rel_y2q_8", y2q_8, 8'h5A);
      check("rel_y4q_8", y4q_8, 8'h44);

      // 2:1 truth table, index = {sel2, a, b}
      for (int i = 0; i < 8; i++) begin
         drive_point();
         sel2 = i[2]; a1 = i[1]; b1 = i[0];
         #1;
         check($sformatf("tt_y2_%0d", i), y2_1, exp2[i]);
         tick();
         check($sformatf("tt_y2q_%0d", i), y2q_1, exp2[i]);
      end

      // 4:1 zero / one-hot / set vectors
      for (int i = 0; i < 10; i++) begin
         drive_point();
         d1 = vec_d[i]; sel4 = vec_s[i];
         #1;
         check($sformatf("v4_y4_%0d", i), y4_1, vec_e[i]);
         tick();
         check($sformatf("v4_y4q_%0d", i), y4q_1, vec_e[i]);
      end

      // enable hold
      drive_point();
      en = 1'b1; sel2 = 1'b0; a1 = 1'b1;
      tick();
      check("hold_load", y2q_1, 1'b1);
      drive_point();
      en = 1'b0; a1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("hold_q_%0d", i), y2q_1, 1'b1);
         check($sformatf("hold_y2_%0d", i), y2_1, 1'b0);
      end
      drive_point();
      en = 1'b1;
      tick();
      check("hold_reload", y2q_1, 1'b0);

      // mid-stream reset, then reload only on an enabled edge
      drive_point();
      a1 = 1'b1;
      tick();
      check("mid_pre", y2q_1, 1'b1);
      drive_point();
      rst_n = 1'b0;
      tick();
      check("mid_rst_q", y2q_1, 1'b0);
      check("mid_rst_ov", ov_1, 1'b0);
      drive_point();
      rst_n = 1'b1; en = 1'b0;
      tick();
      check("mid_noen_ov", ov_1, 1'b0);
      check("mid_noen_q", y2q_1, 1'b0);
      drive_point();
      en = 1'b1;
      tick();
      check("mid_en_ov", ov_1, 1'b1);
      check("mid_en_q", y2q_1, 1'b1);

      // 8-bit lanes
      for (int i = 0; i < 4; i++) begin
         drive_point();
         sel4 = 2'(i);
         #1;
         check($sformatf("w8_y4_%0d", i), y4_8, exp8[i]);
         tick();
         check($sformatf("w8_y4q_%0d", i), y4q_8, exp8[i]);
      end
      drive_point();
      sel2 = 1'b0;
      #1;
      check("w8_y2_a", y2_8, 8'hA5);
      drive_point();
      sel2 = 1'b1;
      #1;
      check("w8_y2_b", y2_8, 8'h5A);
      tick();
      check("w8_y2q_b", y2q_8, 8'h5A);
      drive_point();
      sel2 = 1'b0;
      #1;
      check("w8_y2_a2", y2_8, 8'hA5);

      // unknown select; only observable on a four-state simulator
      probe = 1'bx;
      drive_point();
      sel4 = 2'bx1;
      #1;
      if ($isunknown(probe)) begin
         check("x_sel4", {31'd0, (y4_8 === 8'bxxxxxxxx)}, 32'd1);
      end
      drive_point();
      sel4 = 2'b00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
